keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Key-entry front end for the keylock controller: drives a 4x4 matrix keypad, debounces presses and emits one key event per press.
- Each event is a 4-bit code on keypress plus a single-cycle rdy strobe, matching what the lock FSM consumes.
- Sits between the board keypad pins and the controller.
- Codes used downstream as commands: 7 = abort, 8 = reprogram, 9 = lock/unlock.

Parameters:
- SCAN_DIV, 16: clock cycles each row is driven before its columns are sampled; must be >= 4.
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles required to accept a press or a release; must be >= 2.
- REPEAT_CYCLES, 25000000: auto-repeat period; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- col_n  in  4  keypad column inputs, active-low (pulled up), asynchronous to clk
- row_n  out  4  keypad row drives, one-hot active-low
- keypress  out  4  code of the last accepted key; held until the next event
- rdy  out  1  one-cycle strobe; keypress is valid in the same cycle
- key_down  out  1  high from press acceptance until release is accepted

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Reset values: row_n=4'b1110 (row 0), keypress=0, rdy=0, key_down=0, state=SCAN, all counters 0.
  - Reset asserted mid-operation aborts immediately with the same values; a press in progress is discarded and no rdy is emitted.
- Input synchronisation:
  - col_n passes through a 2-flop synchroniser; all logic uses the synchronised value (cs).
- Key map, code = f(row,col):
  - r0: 1, 2, 3, 10
  - r1: 4, 5, 6, 11
  - r2: 7, 8, 9, 12
  - r3: 14, 0, 15, 13
  - Implemented as a 16-entry constant table.
- Counters:
  - Widths are $clog2(param+1).
  - Counters saturate and never wrap.
- SCAN:
  - Drive the current row.
  - When the dwell counter reaches SCAN_DIV-1, sample cs.
  - Exactly one column low: capture row/column, go to DEBOUNCE.
  - No column low, or more than one low (ghost/multi-key, ignored): advance to the next row (3 wraps to 0) and restart the dwell.
- DEBOUNCE:
  - Row held.
  - Each cycle cs must equal the captured pattern; a mismatch returns to SCAN on the same row with the dwell restarted.
  - After DEBOUNCE_CYCLES consecutive matches, go to REPORT.
- REPORT (1 cycle):
  - rdy=1; keypress=map(row,col) in the same cycle.
  - key_down rises at the end of this cycle.
  - Next state is HOLD.
- HOLD:
  - Row held.
  - cs==4'b1111 for DEBOUNCE_CYCLES consecutive cycles: key_down=0, advance row, go to SCAN.
  - Any low column resets the release count.
  - A second key pressed while held produces no event.
- Latency: from a stable press (post-sync) to rdy is at most 4*SCAN_DIV + DEBOUNCE_CYCLES + 3 cycles.
- Guarantees:
  - rdy is never high for two consecutive cycles.
  - Exactly one rdy per accepted press, unless the optional feature is enabled.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In HOLD, a repeat counter runs while the key stays down.
  - Each time it reaches REPEAT_CYCLES it clears and emits a one-cycle rdy with the same keypress.
  - Release clears the counter.
- Undefined:
  - The repeat logic and the REPEAT_CYCLES use are absent.
  - HOLD emits nothing.

Decomposition:
- Shared package keylock_pkg holds:
  - Key code constants: KEY_ABORT=7, KEY_REPRO=8, KEY_LOCK=9.
  - The key-map table.
  - The state encoding: SCAN, DEBOUNCE, REPORT, HOLD.
- The lock controller imports the same constants.
- Natural sub-module: keypad_sync (2-flop synchroniser, 4 bits wide).

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
- Reset: hold reset 3 cycles -> row_n=1110, rdy=0, keypress=0, key_down=0; first row advance (row_n=1101) SCAN_DIV cycles after reset release.
- Clean press of key "9" (row2/col2, col_n=1011 while row_n=1011), held 40 cycles -> exactly one rdy with keypress=9; key_down high until 8 cycles after release.
- Bounce: toggle col_n every 3 cycles for 30 cycles, then stable "8" -> no rdy during bounce; one rdy with keypress=8 afterwards.
- Ghosting: two columns low on row 0 (col_n=1100) -> no rdy, scanning continues; single key "7" afterwards -> keypress=7.
- Reset mid-press: assert reset during DEBOUNCE (count 5) -> no rdy, row_n=1110 next cycle; full re-press afterwards is accepted.
- KEYPAD_REPEAT_EN with REPEAT_CYCLES=20: hold "0" for 70 cycles -> rdy on acceptance, then 3 further rdy spaced exactly 20 cycles apart, all keypress=0.

Source files
------------

// File: rtl/keylock_pkg.sv
// Shared definitions for the keylock front end and controller: command key
// codes, the 4x4 keypad code table and the scanner state encoding.
package keylock_pkg;

    localparam logic [3:0] KEY_ABORT = 4'd7;
    localparam logic [3:0] KEY_REPRO = 4'd8;
    localparam logic [3:0] KEY_LOCK  = 4'd9;

    // Indexed by {row, col}; column c corresponds to col_n[c], row r to row_n[r].
    localparam logic [3:0] KEY_MAP [16] = '{
        4'd1,      4'd2,      4'd3,     4'd10,
        4'd4,      4'd5,      4'd6,     4'd11,
        KEY_ABORT, KEY_REPRO, KEY_LOCK, 4'd12,
        4'd14,     4'd0,      4'd15,    4'd13
    };

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        REPORT   = 2'd2,
        HOLD     = 2'd3
    } key_state_t;

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous keypad column inputs.
// Resets to all-ones so an idle (pulled-up) keypad is seen from the first cycle.
module keypad_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce; one rdy strobe per accepted press.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner
    import keylock_pkg::*;
#(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] keypress,
    output logic       rdy,
    output logic       key_down
);

    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    w_cs;
    key_state_t    r_state, w_state_nxt;
    logic [1:0]    r_row, w_row_nxt;
    logic [1:0]    r_col, w_col_nxt;
    logic [3:0]    r_pat, w_pat_nxt;
    logic [DW-1:0] r_dwell, w_dwell_nxt;
    logic [BW-1:0] r_deb, w_deb_nxt;
    logic [3:0]    r_keypress, w_keypress_nxt;
    logic          r_rdy, w_rdy_nxt;
    logic          r_key_down, w_key_down_nxt;
    logic          w_single;
    logic [1:0]    w_col_idx;
    logic          w_released;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] r_rep, w_rep_nxt;
`endif

    keypad_sync #(.W(4)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (col_n),
        .o_q   (w_cs)
    );

    // Only a single low column is a valid press; two or more is ghosting.
    always_comb begin
        w_single  = 1'b0;
        w_col_idx = 2'd0;
        case (w_cs)
            4'b1110: begin w_single = 1'b1; w_col_idx = 2'd0; end
            4'b1101: begin w_single = 1'b1; w_col_idx = 2'd1; end
            4'b1011: begin w_single = 1'b1; w_col_idx = 2'd2; end
            4'b0111: begin w_single = 1'b1; w_col_idx = 2'd3; end
            default: begin w_single = 1'b0; w_col_idx = 2'd0; end
        endcase
    end

    assign w_released = (w_cs == 4'b1111);

    always_comb begin
        w_state_nxt    = r_state;
        w_row_nxt      = r_row;
        w_col_nxt      = r_col;
        w_pat_nxt      = r_pat;
        w_dwell_nxt    = r_dwell;
        w_deb_nxt      = r_deb;
        w_keypress_nxt = r_keypress;
        w_rdy_nxt      = 1'b0;
        w_key_down_nxt = r_key_down;
`ifdef KEYPAD_REPEAT_EN
        w_rep_nxt      = r_rep;
`endif
        case (r_state)
            SCAN: begin
                if (r_dwell == DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    w_deb_nxt   = '0;
                    if (w_single) begin
                        w_state_nxt = DEBOUNCE;
                        w_col_nxt   = w_col_idx;
                        w_pat_nxt   = w_cs;
                    end else begin
                        w_row_nxt = r_row + 2'd1;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + DW'(1);
                end
            end
            DEBOUNCE: begin
                if (w_cs != r_pat) begin
                    w_state_nxt = SCAN;
                    w_dwell_nxt = '0;
                    w_deb_nxt   = '0;
                end else if (r_deb == DEB_LAST) begin
                    // rdy and keypress are registered so both are valid in REPORT.
                    w_state_nxt    = REPORT;
                    w_deb_nxt      = '0;
                    w_rdy_nxt      = 1'b1;
                    w_keypress_nxt = key_code(r_row, r_col);
                end else begin
                    w_deb_nxt = r_deb + BW'(1);
                end
            end
            REPORT: begin
                w_state_nxt    = HOLD;
                w_key_down_nxt = 1'b1;
                w_deb_nxt      = '0;
`ifdef KEYPAD_REPEAT_EN
                w_rep_nxt      = RW'(1);
`endif
            end
            HOLD: begin
                if (w_released) begin
`ifdef KEYPAD_REPEAT_EN
                    w_rep_nxt = '0;
`endif
                    if (r_deb == DEB_LAST) begin
                        w_state_nxt    = SCAN;
                        w_key_down_nxt = 1'b0;
                        w_row_nxt      = r_row + 2'd1;
                        w_dwell_nxt    = '0;
                        w_deb_nxt      = '0;
                    end else begin
                        w_deb_nxt = r_deb + BW'(1);
                    end
                end else begin
                    w_deb_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
                    if (r_rep == REP_LAST) begin
                        w_rep_nxt = '0;
                        w_rdy_nxt = 1'b1;
                    end else begin
                        w_rep_nxt = r_rep + RW'(1);
                    end
`endif
                end
            end
            default: w_state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= SCAN;
            r_row      <= 2'd0;
            r_col      <= 2'd0;
            r_pat      <= 4'hF;
            r_dwell    <= '0;
            r_deb      <= '0;
            r_keypress <= 4'd0;
            r_rdy      <= 1'b0;
            r_key_down <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep      <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_row      <= w_row_nxt;
            r_col      <= w_col_nxt;
            r_pat      <= w_pat_nxt;
            r_dwell    <= w_dwell_nxt;
            r_deb      <= w_deb_nxt;
            r_keypress <= w_keypress_nxt;
            r_rdy      <= w_rdy_nxt;
            r_key_down <= w_key_down_nxt;
`ifdef KEYPAD_REPEAT_EN
            r_rep      <= w_rep_nxt;
`endif
        end
    end

    assign row_n    = ~(4'b0001 << r_row);
    assign keypress = r_keypress;
    assign rdy      = r_rdy;
    assign key_down = r_key_down;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=20)
// with a behavioural keypad that pulls chosen columns low while their row is driven.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] keypress;
    logic       rdy;
    logic       key_down;

    logic       key_en = 1'b0;
    logic [1:0] key_row = 2'd0;
    logic [3:0] key_cols = 4'd0;

    int checks = 0;
    int failures = 0;
    int rdy_count = 0;
    logic prev_rdy = 1'b0;

    always #5 clk = ~clk;

    assign col_n = (key_en && (row_n[key_row] === 1'b0)) ? ~key_cols : 4'hF;

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8),
        .REPEAT_CYCLES   (20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .col_n    (col_n),
        .row_n    (row_n),
        .keypress (keypress),
        .rdy      (rdy),
        .key_down (key_down)
    );

    // Count strobes and flag any strobe that directly follows another.
    always @(negedge clk) begin
        if (rdy === 1'b1) begin
            rdy_count = rdy_count + 1;
            checks = checks + 1;
            assert (prev_rdy === 1'b0) else begin
                failures = failures + 1;
                $error("FAIL rdy_back_to_back: observed prev_rdy=%b expected 0", prev_rdy);
            end
        end
        prev_rdy = rdy;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_rdy(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_keyup(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (key_down === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit         ok;
        int         base;
        logic [3:0] rs;
        int         pos[$];

        // Reset state and first row advance
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_row_n", 32'(row_n), 32'(4'b1110));
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_keypress", 32'(keypress), 32'd0);
        chk("rst_key_down", 32'(key_down), 32'd0);
        reset = 1'b0;
        repeat (3) tick();
        chk("row0_dwell", 32'(row_n), 32'(4'b1110));
        tick();
        chk("row1_advance", 32'(row_n), 32'(4'b1101));

        // Clean press of key 9 (row 2, col 2)
        key_row = 2'd2; key_cols = 4'b0100; key_en = 1'b1;
        base = rdy_count;
        wait_rdy(40, ok);
        chk("key9_rdy_seen", 32'(ok), 32'd1);
        chk("key9_code", 32'(keypress), 32'd9);
        chk("key9_down_in_report", 32'(key_down), 32'd0);
        tick();
        chk("key9_down_after", 32'(key_down), 32'd1);
        repeat (30) tick();
        chk("key9_single_rdy", 32'(rdy_count - base), 32'd1);
        key_en = 1'b0;
        repeat (9) tick();
        chk("key9_release_pending", 32'(key_down), 32'd1);
        tick();
        chk("key9_release_done", 32'(key_down), 32'd0);
        chk("key9_row_next", 32'(row_n), 32'(4'b0111));

        // Bouncing contact on key 8, then a stable press
        key_row = 2'd2; key_cols = 4'b0010;
        base = rdy_count;
        for (int i = 0; i < 10; i++) begin
            key_en = ((i % 2) == 0);
            repeat (3) tick();
        end
        chk("bounce_no_rdy", 32'(rdy_count - base), 32'd0);
        key_en = 1'b1;
        wait_rdy(40, ok);
        chk("key8_rdy_seen", 32'(ok), 32'd1);
        chk("key8_code", 32'(keypress), 32'd8);
        key_en = 1'b0;
        wait_keyup(20, ok);
        chk("key8_release", 32'(ok), 32'd1);

        // Two columns low on row 0 is ignored and scanning keeps going
        key_row = 2'd0; key_cols = 4'b0011; key_en = 1'b1;
        base = rdy_count;
        repeat (40) tick();
        chk("ghost_no_rdy", 32'(rdy_count - base), 32'd0);
        rs = row_n;
        repeat (4) tick();
        chk("ghost_scan_moves", 32'(row_n), 32'({rs[2:0], rs[3]}));
        key_row = 2'd2; key_cols = 4'b0001;
        wait_rdy(40, ok);
        chk("key7_rdy_seen", 32'(ok), 32'd1);
        chk("key7_code", 32'(keypress), 32'd7);
        key_en = 1'b0;
        wait_keyup(20, ok);
        chk("key7_release", 32'(ok), 32'd1);

        // Release just advanced to row 3 with a fresh dwell: press key 14 there,
        // sample lands 4 cycles later, so 9 cycles in the debounce count is 5.
        key_row = 2'd3; key_cols = 4'b0001; key_en = 1'b1;
        base = rdy_count;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        chk("midrst_row_n", 32'(row_n), 32'(4'b1110));
        chk("midrst_key_down", 32'(key_down), 32'd0);
        chk("midrst_keypress", 32'(keypress), 32'd0);
        chk("midrst_rdy", 32'(rdy), 32'd0);
        reset = 1'b0;
        tick();
        chk("midrst_no_rdy", 32'(rdy_count - base), 32'd0);
        wait_rdy(40, ok);
        chk("key14_rdy_seen", 32'(ok), 32'd1);
        chk("key14_code", 32'(keypress), 32'd14);
        key_en = 1'b0;
        wait_keyup(20, ok);
        chk("key14_release", 32'(ok), 32'd1);

        // Hold key 0 (row 3, col 1); auto-repeat only when the feature is built in
        key_row = 2'd3; key_cols = 4'b0010; key_en = 1'b1;
        wait_rdy(40, ok);
        chk("key0_rdy_seen", 32'(ok), 32'd1);
        chk("key0_code", 32'(keypress), 32'd0);
        for (int k = 1; k <= 65; k++) begin
            tick();
            if (rdy === 1'b1) pos.push_back(k);
        end
`ifdef KEYPAD_REPEAT_EN
        chk("repeat_count", 32'(pos.size()), 32'd3);
        chk("repeat_pos1", 32'((pos.size() > 0) ? pos[0] : -1), 32'd20);
        chk("repeat_pos2", 32'((pos.size() > 1) ? pos[1] : -1), 32'd40);
        chk("repeat_pos3", 32'((pos.size() > 2) ? pos[2] : -1), 32'd60);
`else
        chk("hold_no_repeat", 32'(pos.size()), 32'd0);
`endif
        chk("key0_code_held", 32'(keypress), 32'd0);
        key_en = 1'b0;
        wait_keyup(20, ok);
        chk("key0_release", 32'(ok), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
